// File: rtl/spi_slave_dispatch_if.sv
// Bundle of SPI pin, status and target-side signals for spi_slave_dispatch.
// The slave modport is the dispatcher's view; master is the driving side
// (pins, status source and downstream targets).
interface spi_slave_dispatch_if #(
  parameter int NT = 4
);
  logic          spi_sck;
  logic          spi_cs_n;
  logic          spi_mosi;
  logic          spi_miso;
  logic [7:0]    status;
  logic          rising;
  logic          falling;
  logic          si;
  logic          reset_flag;
  logic [NT-1:0] sel;
  logic [NT-1:0] so_in;
  logic [7:0]    cmd;
  logic          cmd_valid;

  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi, status, so_in,
    output spi_miso, rising, falling, si, reset_flag, sel, cmd, cmd_valid
  );

  modport master (
    output spi_sck, spi_cs_n, spi_mosi, status, so_in,
    input  spi_miso, rising, falling, si, reset_flag, sel, cmd, cmd_valid
  );
endinterface

// File: rtl/spi_slave_dispatch.sv
// SPI mode-0 slave front end. Synchronises the raw pins into clk, produces
// SCK edge strobes and a per-transaction reset_flag, decodes the first byte
// of each transaction as a command and routes one target onto MISO.
module spi_slave_dispatch #(
  parameter int NT   = 4,
  parameter int SYNC = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  spi_slave_dispatch_if.slave  bus
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CMD      = 2'd1;
  localparam logic [1:0] ST_DISPATCH = 2'd2;
  localparam logic [1:0] ST_DRAIN    = 2'd3;

  // Pin synchronisers and edge-detect history
  logic [SYNC-1:0] sck_sync;
  logic [SYNC-1:0] cs_sync;
  logic [SYNC-1:0] mosi_sync;
  logic [SYNC-1:0] fill;
  logic            sck_d;
  logic            cs_d;
  logic            armed;

  logic sck_s, cs_s, mosi_s;
  logic cs_act, cs_fall, cs_rise;

  // Registered outputs
  logic          rising_q;
  logic          falling_q;
  logic          si_q;
  logic          reset_flag_q;
  logic          cmd_valid_q;
  logic          miso_q;
  logic [NT-1:0] sel_q;
  logic [7:0]    cmd_q;

  // FSM state
  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] cmd_sr;
  logic [7:0] stat_sr;

  // Command decode
  logic [7:0]    cmd_byte;
  logic          cmd_ok;
  logic [NT-1:0] tgt_sel;
  logic          tgt_so;

  assign sck_s  = sck_sync[SYNC-1];
  assign cs_s   = cs_sync[SYNC-1];
  assign mosi_s = mosi_sync[SYNC-1];

  // The synchroniser's reset value for CS is only a stand-in for the pin.
  // Until the chain has refilled and shown CS high, a low CS is a leftover
  // of a transaction cut by reset and must not start a new one.
  assign cs_act  = ~cs_s & armed;
  assign cs_fall = cs_d & ~cs_s & armed;
  assign cs_rise = cs_s & ~cs_d;

  // Synchronise pins into clk and remember the previous synchronised levels
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so that all flops in the
    // chain sample the values from before the edge; blocking here would
    // collapse the synchroniser into a single stage.
    if (!reset_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      fill      <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC-2:0], bus.spi_sck};
      cs_sync   <= {cs_sync[SYNC-2:0], bus.spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC-2:0], bus.spi_mosi};
      fill      <= {fill[SYNC-2:0], 1'b1};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
      if (cs_s && fill[SYNC-1]) armed <= 1'b1;
    end
  end

  // Registered SCK edge strobes, aligned MOSI sample and transaction pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rising_q     <= 1'b0;
      falling_q    <= 1'b0;
      si_q         <= 1'b0;
      reset_flag_q <= 1'b0;
    end else begin
      rising_q     <= sck_s & ~sck_d & cs_act;
      falling_q    <= ~sck_s & sck_d & cs_act;
      si_q         <= mosi_s;
      reset_flag_q <= cs_fall;
    end
  end

  // Assemble the command byte and decode the selected target
  always_comb begin
    // NOTE: each output of this block gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    cmd_byte = {cmd_sr[6:0], si_q};
    cmd_ok   = cmd_byte[7] && ({1'b0, cmd_byte[2:0]} < 4'(NT));
    tgt_sel  = '0;
    tgt_so   = 1'b0;
    for (int i = 0; i < NT; i++) begin
      if (cmd_q[2:0] == 3'(i)) begin
        tgt_sel[i] = 1'b1;
        tgt_so     = bus.so_in[i];
      end
    end
  end

  // Transaction FSM: command capture, target dispatch and MISO drive
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= 3'd0;
      cmd_sr      <= 8'h00;
      stat_sr     <= 8'h00;
      cmd_q       <= 8'h00;
      cmd_valid_q <= 1'b0;
      sel_q       <= '0;
      miso_q      <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      if (cs_rise) begin
        // CS released: abandon whatever was in progress, partial bytes included
        state  <= ST_IDLE;
        sel_q  <= '0;
        miso_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state   <= ST_CMD;
              stat_sr <= bus.status;
              miso_q  <= bus.status[7];
              bit_cnt <= 3'd0;
              cmd_sr  <= 8'h00;
            end
          end
          ST_CMD: begin
            if (rising_q) begin
              cmd_sr <= cmd_byte;
              if (bit_cnt == 3'd7) begin
                // Counter stays at 7 so later bytes cannot re-enter CMD
                cmd_q <= cmd_byte;
                if (cmd_ok) begin
                  cmd_valid_q <= 1'b1;
                  state       <= ST_DISPATCH;
                end else begin
                  state <= ST_DRAIN;
                end
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
            if (falling_q) begin
              // Mode 0: next status bit goes out on the falling edge, MSB first
              stat_sr <= {stat_sr[6:0], 1'b0};
              miso_q  <= stat_sr[6];
            end
          end
          ST_DISPATCH: begin
            sel_q  <= tgt_sel;
            miso_q <= tgt_so;
          end
          ST_DRAIN: begin
            sel_q  <= '0;
            miso_q <= 1'b0;
          end
          default: begin
            state  <= ST_IDLE;
            sel_q  <= '0;
            miso_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rising     = rising_q;
  assign bus.falling    = falling_q;
  assign bus.si         = si_q;
  assign bus.reset_flag = reset_flag_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.cmd        = cmd_q;
  assign bus.sel        = sel_q;
  assign bus.spi_miso   = miso_q;

endmodule

// File: tb/tb_spi_slave_dispatch.sv
// Scoreboard bench for spi_slave_dispatch: stimulus tasks push the expected
// per-bit and per-command responses, monitors pop and compare them whenever
// the DUT strobes rising or cmd_valid.
module tb_spi_slave_dispatch;

  localparam int NT   = 4;
  localparam int SYNC = 2;
  localparam int HALF = 8;   // clk cycles per SCK half period

  typedef struct {
    logic          si;
    logic          miso;
    logic [NT-1:0] sel;
  } rec_t;

  logic clk = 1'b0;
  logic reset_n;

  spi_slave_dispatch_if #(.NT(NT)) bus ();

  spi_slave_dispatch #(.NT(NT), .SYNC(SYNC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int   pass_cnt  = 0;
  int   check_cnt = 0;
  int   rf_cnt    = 0;
  int   exp_rf    = 0;
  int   fall_cnt  = 0;
  int   exp_fall  = 0;
  bit   strobe_on = 1'b1;
  bit   sel_seen  = 1'b0;
  bit   sel_pending = 1'b0;
  logic [NT-1:0] pend_sel;

  rec_t       rec_q[$];
  logic [7:0] cmd_exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [NT-1:0] onehot(input logic [2:0] i);
    logic [NT-1:0] v;
    for (int j = 0; j < NT; j++) v[j] = (int'(i) == j);
    return v;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compares DUT responses one tick after each active edge
  always @(posedge clk) begin
    rec_t       r;
    logic [7:0] c;
    #1;
    if (reset_n) begin
      if (bus.sel != '0) sel_seen = 1'b1;
      if (bus.reset_flag) rf_cnt++;
      if (bus.falling && strobe_on) fall_cnt++;
      if (sel_pending) begin
        check("sel_after_cmd_valid", 32'(bus.sel), 32'(pend_sel));
        sel_pending = 1'b0;
      end
      if (bus.rising && strobe_on) begin
        check("rising_expected", 32'(rec_q.size() != 0), 1);
        if (rec_q.size() != 0) begin
          r = rec_q.pop_front();
          check("si", 32'(bus.si), 32'(r.si));
          check("miso_at_rising", 32'(bus.spi_miso), 32'(r.miso));
          check("sel_at_rising", 32'(bus.sel), 32'(r.sel));
        end
      end
      if (bus.cmd_valid) begin
        check("cmd_valid_expected", 32'(cmd_exp_q.size() != 0), 1);
        if (cmd_exp_q.size() != 0) begin
          c = cmd_exp_q.pop_front();
          check("cmd", 32'(bus.cmd), 32'(c));
          check("sel_low_at_cmd_valid", 32'(bus.sel), 0);
          pend_sel    = onehot(c[2:0]);
          sel_pending = 1'b1;
        end
      end
    end
  end

  // One transaction: CS low, nbits MSB-first from bits[23], optional CS release.
  // so_pat gives the selected target's output for each post-command bit.
  task automatic run_frame(input logic [7:0] st, input logic [23:0] bits, input int nbits,
                           input logic [15:0] so_pat, input bit end_cs);
    logic [7:0] c0;
    bit         valid;
    int         idx;
    rec_t       r;
    c0    = bits[23:16];
    idx   = int'(c0[2:0]);
    valid = c0[7] && (idx < NT);
    bus.status = st;
    bus.so_in  = '0;
    @(negedge clk) bus.spi_cs_n = 1'b0;
    exp_rf++;
    exp_fall += nbits;
    if (nbits >= 8 && valid) cmd_exp_q.push_back(c0);
    for (int k = 0; k < nbits; k++) begin
      bus.spi_mosi = bits[23-k];
      r.si = bits[23-k];
      if (k < 8) begin
        r.miso = st[7-k];
        r.sel  = '0;
      end else if (valid) begin
        r.miso = bus.so_in[idx];
        r.sel  = onehot(c0[2:0]);
      end else begin
        r.miso = 1'b0;
        r.sel  = '0;
      end
      rec_q.push_back(r);
      wait_clks(HALF);
      bus.spi_sck = 1'b1;
      wait_clks(HALF);
      bus.spi_sck = 1'b0;
      if (k >= 7 && k - 7 < 16) begin
        if (valid) begin
          bus.so_in      = {NT{~so_pat[15-(k-7)]}};
          bus.so_in[idx] = so_pat[15-(k-7)];
        end else begin
          bus.so_in = NT'($urandom);
        end
      end
    end
    wait_clks(HALF);
    if (end_cs) begin
      bus.spi_cs_n = 1'b1;
      wait_clks(2 * HALF);
    end
  endtask

  task automatic settle(input string tag);
    wait_clks(4);
    check({tag, "_bits_left"}, 32'(rec_q.size()), 0);
    check({tag, "_cmds_left"}, 32'(cmd_exp_q.size()), 0);
    check({tag, "_reset_flags"}, 32'(rf_cnt), 32'(exp_rf));
    check({tag, "_falling_strobes"}, 32'(fall_cnt), 32'(exp_fall));
    check({tag, "_sel_idle"}, 32'(bus.sel), 0);
    check({tag, "_miso_idle"}, 32'(bus.spi_miso), 0);
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.spi_sck  = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.status   = 8'h00;
    bus.so_in    = '0;

    // 1: reset with idle pins, all outputs stay zero
    wait_clks(3);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_outputs", 32'({bus.rising, bus.falling, bus.si, bus.reset_flag,
                                  bus.sel, bus.cmd, bus.cmd_valid, bus.spi_miso}), 0);
    end

    // 2: command 0x81 then 0x3C,0x5A -> target 1 for 16 bits
    run_frame(8'hC3, 24'h813C5A, 24, 16'hB2D4, 1'b1);
    settle("t2");
    check("t2_cmd", 32'(bus.cmd), 32'h81);

    // 3: status 0xA5 shifted out during command 0x80
    run_frame(8'hA5, 24'h800000, 8, 16'h0000, 1'b1);
    settle("t3");
    check("t3_cmd", 32'(bus.cmd), 32'h80);

    // 4: invalid commands: bit7 clear, then index beyond NT
    run_frame(8'h5A, 24'h05FF00, 16, 16'hFFFF, 1'b1);
    run_frame(8'h5A, 24'h86F000, 16, 16'hFFFF, 1'b1);
    settle("t4");
    check("t4_cmd_captured", 32'(bus.cmd), 32'h86);

    // 5: CS released after 5 bits, then a full 0x82 frame
    run_frame(8'h96, 24'hF80000, 5, 16'h0000, 1'b1);
    settle("t5a");
    check("t5_partial_discarded", 32'(bus.cmd), 32'h86);
    run_frame(8'h69, 24'h82C500, 16, 16'h5AC3, 1'b1);
    settle("t5b");
    check("t5_cmd", 32'(bus.cmd), 32'h82);

    // 6: reset mid-DISPATCH with CS held low
    run_frame(8'h0F, 24'h81FF00, 11, 16'hE000, 1'b0);
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    check("t6_sel_after_reset", 32'(bus.sel), 0);
    check("t6_miso_after_reset", 32'(bus.spi_miso), 0);
    check("t6_cmd_after_reset", 32'(bus.cmd), 0);
    strobe_on = 1'b0;
    sel_seen  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.spi_mosi = k[0];
      wait_clks(HALF);
      bus.spi_sck = 1'b1;
      wait_clks(HALF);
      bus.spi_sck = 1'b0;
    end
    wait_clks(HALF);
    check("t6_sel_stays_low", 32'(sel_seen), 0);
    check("t6_no_reset_flag", 32'(rf_cnt), 32'(exp_rf));
    bus.spi_cs_n = 1'b1;
    wait_clks(2 * HALF);
    strobe_on = 1'b1;
    run_frame(8'h33, 24'h83A700, 16, 16'h9C3E, 1'b1);
    settle("t6");
    check("t6_cmd", 32'(bus.cmd), 32'h83);

    wait_clks(4);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks so far", pass_cnt, check_cnt);
    $fatal(1, "timeout");
  end

endmodule
